// File: rtl/apb3_m_arbiter.sv
// apb3_m_arbiter: round-robin arbiter in front of an APB3 master sequencer.
// NUM_REQ local requesters each post one transfer on a req/ack handshake.
// The winner is carried through SETUP and ACCESS. Completion comes from PREADY
// or from a wait-state timeout, and is reported combinationally on ack/rsp_*.
module apb3_m_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned STRB_W   = 4,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_strb,
    input  logic [NUM_REQ*3-1:0]  req_prot,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [STRB_W-1:0]     PSTRB,
    output logic [2:0]            PPROT,
    input  logic                  PREADY,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PSLVERR
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [STRB_W-1:0]  pstrb_q, pstrb_d;
    logic [2:0]         pprot_q, pprot_d;

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   scan_idx;
    int unsigned        scan_full;
    logic               timeout;
    logic               done;

    // Round-robin search: first requester at or after rr_ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_full = 0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_full = (32'(rr_ptr_q) + k) % NUM_REQ;
            scan_idx  = PTR_W'(scan_full);
            if (!gnt_found && req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign timeout = (state_q == ST_ACCESS) && !PREADY && (wait_cnt_q == WAIT_LAST);
    assign done    = (state_q == ST_ACCESS) && (PREADY || timeout);

    // Completion response, valid only in the cycle that ends the transfer
    always_comb begin
        ack       = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (done) begin
            ack[gnt_q] = 1'b1;
            rsp_err    = timeout || PSLVERR;
            rsp_rdata  = (PREADY && !pwrite_q) ? PRDATA : '0;
        end
    end

    // Next-state and APB output computation
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        wait_cnt_d = wait_cnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pprot_d    = pprot_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    state_d  = ST_SETUP;
                    gnt_d    = gnt_idx;
                    rr_ptr_d = PTR_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
                    psel_d   = 1'b1;
                    pwrite_d = req_write[gnt_idx];
                    paddr_d  = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
                    pwdata_d = req_wdata[32'(gnt_idx)*DATA_W +: DATA_W];
                    pstrb_d  = req_strb[32'(gnt_idx)*STRB_W +: STRB_W];
                    pprot_d  = req_prot[32'(gnt_idx)*3 +: 3];
                end
            end
            ST_SETUP: begin
                state_d    = ST_ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ST_ACCESS: begin
                if (done) begin
                    state_d   = ST_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered APB outputs; reset kills any transfer in flight
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            wait_cnt_q <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            pprot_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            wait_cnt_q <= wait_cnt_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            pprot_q    <= pprot_d;
        end
    end

    assign PSELx   = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;
    assign PPROT   = pprot_q;

endmodule

// File: tb/tb_apb3_m_arbiter.sv
// tb_apb3_m_arbiter: directed scenarios plus randomized traffic for apb3_m_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_apb3_m_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int MW = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N*3-1:0]  req_prot;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            PSELx, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [SW-1:0]   PSTRB;
    logic [2:0]      PPROT;
    logic            PREADY = 1'b0;
    logic [DW-1:0]   PRDATA = '0;
    logic            PSLVERR = 1'b0;

    logic [AW-1:0] r_addr  [N];
    logic [DW-1:0] r_wdata [N];
    logic [SW-1:0] r_strb  [N];
    logic [2:0]    r_prot  [N];

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = r_addr[i];
            req_wdata[i*DW +: DW] = r_wdata[i];
            req_strb[i*SW +: SW]  = r_strb[i];
            req_prot[i*3 +: 3]    = r_prot[i];
        end
    end

    apb3_m_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .STRB_W  (SW),
        .MAX_WAIT(MW)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_strb (req_strb),
        .req_prot (req_prot),
        .ack      (ack),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSELx    (PSELx),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PPROT    (PPROT),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transfer, its owner, cycles since grant, wait states seen
    bit          m_busy = 0;
    int          m_owner = 0;
    int          m_cyc = 0;
    int          m_waits = 0;
    int          m_ptr = 0;
    logic        m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;

    int          last_ack = -1;
    logic [DW-1:0] last_rdata;
    logic        last_err;

    // Called at a negedge with inputs already set; checks outputs, advances the model, waits one cycle
    task automatic cycle();
        logic         done;
        logic [N-1:0] e_ack;
        #1;
        done  = PRESETn && m_busy && (m_cyc >= 1) && (PREADY || (m_waits == MW - 1));
        e_ack = '0;
        if (done) e_ack[m_owner] = 1'b1;
        check("psel", PSELx, m_busy);
        check("penable", PENABLE, m_busy && (m_cyc >= 1));
        check("ack", ack, e_ack);
        check("rsp_rdata", rsp_rdata, (done && PREADY && !m_write) ? PRDATA : '0);
        check("rsp_err", rsp_err, done && (!PREADY || PSLVERR));
        if (m_busy) begin
            check("pwrite", PWRITE, m_write);
            check("paddr", PADDR, m_addr);
            check("pwdata", PWDATA, m_wdata);
            check("pstrb", PSTRB, m_strb);
            check("pprot", PPROT, m_prot);
        end
        last_ack   = done ? m_owner : -1;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        if (!PRESETn) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            if (|req) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        break;
                    end
                end
                m_ptr   = (m_owner + 1) % N;
                m_busy  = 1;
                m_cyc   = 0;
                m_waits = 0;
                m_write = req_write[m_owner];
                m_addr  = r_addr[m_owner];
                m_wdata = r_wdata[m_owner];
                m_strb  = r_strb[m_owner];
                m_prot  = r_prot[m_owner];
            end
        end else if (m_cyc == 0) begin
            m_cyc = 1;
        end else if (done) begin
            m_busy = 0;
        end else begin
            m_waits++;
        end
        @(negedge PCLK);
    endtask

    task automatic run_until_ack(input int max_cyc, output int n);
        n = 0;
        do begin
            n++;
            cycle();
        end while (last_ack < 0 && n <= max_cyc);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
        req[i]       = 1'b1;
        req_write[i] = wr;
        r_addr[i]    = a;
        r_wdata[i]   = d;
        r_strb[i]    = s;
        r_prot[i]    = p;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom_range(1)), $urandom, $urandom,
                SW'($urandom_range(15)), 3'($urandom_range(7)));
    endtask

    task automatic apply_reset();
        PRESETn = 1'b0;
        #1;
        m_busy = 0;
        m_ptr  = 0;
        cycle();
        cycle();
        PRESETn = 1'b1;
    endtask

    int n;
    int stall;

    initial begin
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0; r_prot[i] = '0;
        end
        @(negedge PCLK);

        // Reset state and idle bus with no requests
        cycle();
        check("rst_paddr", PADDR, '0);
        check("rst_pwdata", PWDATA, '0);
        check("rst_pstrb", PSTRB, '0);
        check("rst_pprot", PPROT, '0);
        check("rst_pwrite", PWRITE, 1'b0);
        PRESETn = 1'b1;
        repeat (10) cycle();

        // Single write from requester 1, zero wait states
        PREADY = 1'b1;
        set_req(1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd0);
        run_until_ack(10, n);
        check("t2_latency", n, 3);
        check("t2_grant", last_ack, 1);
        check("t2_err", last_err, 1'b0);
        req[1] = 1'b0;
        cycle();

        // All four requesting: round-robin order 0,1,2,3,0
        apply_reset();
        PREADY = 1'b1;
        for (int i = 0; i < N; i++) rand_req(i);
        for (int k = 0; k < 5; k++) begin
            run_until_ack(10, n);
            check("t3_latency", n, 3);
            check("t3_grant", last_ack, k % N);
            if (last_ack >= 0) rand_req(last_ack);
        end
        req = '0;
        cycle();

        // Read with five wait states
        PREADY = 1'b0;
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'd2);
        repeat (7) cycle();
        PREADY = 1'b1;
        PRDATA = 32'h1234;
        cycle();
        check("t4_grant", last_ack, 2);
        check("t4_rdata", last_rdata, 32'h1234);
        req[2] = 1'b0;
        cycle();

        // PREADY stuck low: timeout after MAX_WAIT access cycles
        PREADY = 1'b0;
        set_req(3, 1'b0, 32'h44, 32'h0, 4'h0, 3'd1);
        run_until_ack(40, n);
        check("t5_latency", n, 2 + MW);
        check("t5_grant", last_ack, 3);
        check("t5_err", last_err, 1'b1);
        check("t5_rdata", last_rdata, '0);
        req[3] = 1'b0;
        cycle();

        // Reset during the second access cycle kills the transfer
        set_req(1, 1'b0, 32'h80, 32'h0, 4'h0, 3'd0);
        repeat (3) cycle();
        PRESETn = 1'b0;
        #1;
        check("t6_psel_drop", PSELx, 1'b0);
        check("t6_penable_drop", PENABLE, 1'b0);
        check("t6_no_ack", ack, '0);
        m_busy = 0;
        m_ptr  = 0;
        req[1] = 1'b0;
        rand_req(0);
        rand_req(3);
        PREADY = 1'b1;
        cycle();
        cycle();
        PRESETn = 1'b1;
        run_until_ack(10, n);
        check("t6_latency", n, 3);
        check("t6_first", last_ack, 0);
        req = '0;
        cycle();

        // Randomized traffic with random wait states and occasional long stalls
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ack == i) begin
                    if ($urandom_range(1) == 1) rand_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    rand_req(i);
                end
            end
            if (stall > 0) begin
                PREADY = 1'b0;
                stall--;
            end else begin
                if ($urandom_range(99) == 0) stall = 20;
                PREADY = ($urandom_range(2) != 0);
            end
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
